// File: rtl/lsu_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_unit_pkg : core pipeline and LSU state encodings shared by GPU  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package lsu_unit_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_unit_timeout_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_timeout_counter : WAITING-cycle counter with terminal flag      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module lsu_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int CNT_BITS = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CNT_BITS'(1);
        end
    end

    // High during the WAITING cycle whose miss would bring the count to TIMEOUT_CYCLES.
    assign terminal = (count == CNT_BITS'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_unit : per-thread load/store unit with ready timeout abort     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    lsu_state_t           state, state_next;
    logic                 is_read, is_read_next;
    logic                 read_valid_next, write_valid_next;
    logic [ADDR_BITS-1:0] read_addr_next, write_addr_next;
    logic [DATA_BITS-1:0] write_data_next, lsu_out_next;
    logic                 lsu_error_next;
    logic                 ready_hit, timeout_hit;

    assign ready_hit = is_read ? mem_read_ready : mem_write_ready;
    assign lsu_state = state;

    lsu_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == LSU_REQUESTING),
        .count_en((state == LSU_WAITING) && !ready_hit),
        .terminal(timeout_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= LSU_IDLE;
            is_read           <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
            lsu_error         <= 1'b0;
        end else begin
            state             <= state_next;
            is_read           <= is_read_next;
            mem_read_valid    <= read_valid_next;
            mem_read_address  <= read_addr_next;
            mem_write_valid   <= write_valid_next;
            mem_write_address <= write_addr_next;
            mem_write_data    <= write_data_next;
            lsu_out           <= lsu_out_next;
            lsu_error         <= lsu_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        is_read_next     = is_read;
        read_valid_next  = mem_read_valid;
        read_addr_next   = mem_read_address;
        write_valid_next = mem_write_valid;
        write_addr_next  = mem_write_address;
        write_data_next  = mem_write_data;
        lsu_out_next     = lsu_out;
        lsu_error_next   = lsu_error;

        case (state)
            LSU_IDLE: begin
                if (enable && (core_state == CORE_REQUEST) &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    state_next   = LSU_REQUESTING;
                    // A read takes priority when both decodes are set.
                    is_read_next = decoded_mem_read_enable;
                end
            end
            LSU_REQUESTING: begin
                state_next = LSU_WAITING;
                if (is_read) begin
                    read_valid_next = 1'b1;
                    read_addr_next  = ADDR_BITS'(rs);
                end else begin
                    write_valid_next = 1'b1;
                    write_addr_next  = ADDR_BITS'(rs);
                    write_data_next  = DATA_BITS'(rt);
                end
            end
            LSU_WAITING: begin
                // Ready is tested first so a same-cycle timeout never flags an error.
                if (ready_hit) begin
                    state_next       = LSU_DONE;
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    if (is_read) begin
                        lsu_out_next = mem_read_data;
                    end
                end else if (timeout_hit) begin
                    state_next       = LSU_DONE;
                    read_valid_next  = 1'b0;
                    write_valid_next = 1'b0;
                    lsu_error_next   = 1'b1;
                    if (is_read) begin
                        lsu_out_next = '0;
                    end
                end
            end
            LSU_DONE: begin
                if (core_state == CORE_UPDATE) begin
                    state_next = LSU_IDLE;
                end
            end
            default: state_next = LSU_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_unit : directed + random transactions against a cycle model |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    localparam int TMO = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       decoded_mem_read_enable;
    logic       decoded_mem_write_enable;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_out = 8'h00;
    logic       exp_err = 1'b0;

    lsu_unit #(
        .ADDR_BITS     (8),
        .DATA_BITS     (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .core_state              (core_state),
        .decoded_mem_read_enable (decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .rs                      (rs),
        .rt                      (rt),
        .mem_read_valid          (mem_read_valid),
        .mem_read_address        (mem_read_address),
        .mem_read_ready          (mem_read_ready),
        .mem_read_data           (mem_read_data),
        .mem_write_valid         (mem_write_valid),
        .mem_write_address       (mem_write_address),
        .mem_write_data          (mem_write_data),
        .mem_write_ready         (mem_write_ready),
        .lsu_state               (lsu_state),
        .lsu_out                 (lsu_out),
        .lsu_error               (lsu_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(lsu_state), 0);
        chk({tag, "_valids"}, {30'd0, mem_read_valid, mem_write_valid}, 0);
        chk({tag, "_addrs"}, {16'd0, mem_read_address, mem_write_address}, 0);
        chk({tag, "_wdata"}, 32'(mem_write_data), 0);
        chk({tag, "_out"}, 32'(lsu_out), 0);
        chk({tag, "_error"}, 32'(lsu_error), 0);
    endtask

    // rdy_at: index of the WAITING cycle that sees ready; >= TMO means never.
    task automatic run_txn(input logic rd_en, input logic wr_en, input logic [7:0] a,
                           input logic [7:0] wd, input int rdy_at);
        logic       is_rd;
        logic       timed_out;
        logic [7:0] captured;
        int         beats;
        is_rd     = rd_en;
        timed_out = (rdy_at >= TMO);
        captured  = 8'h00;
        core_state               = CORE_REQUEST;
        decoded_mem_read_enable  = rd_en;
        decoded_mem_write_enable = wr_en;
        rs = a;
        rt = wd;
        chk("pre_idle", 32'(lsu_state), 0);
        @(negedge clk);
        chk("requesting_state", 32'(lsu_state), 1);
        chk("requesting_no_valid", {30'd0, mem_read_valid, mem_write_valid}, 0);
        core_state               = CORE_WAIT;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        beats = 0;
        for (int i = 0; i < TMO + 3; i++) begin
            @(negedge clk);
            if (!(is_rd ? mem_read_valid : mem_write_valid)) break;
            beats++;
            chk("waiting_state", 32'(lsu_state), 2);
            if (is_rd) begin
                chk("read_addr", 32'(mem_read_address), 32'(a));
                chk("no_write_valid", 32'(mem_write_valid), 0);
            end else begin
                chk("write_addr", 32'(mem_write_address), 32'(a));
                chk("write_data", 32'(mem_write_data), 32'(wd));
                chk("no_read_valid", 32'(mem_read_valid), 0);
            end
            rs              = 8'($urandom);
            rt              = 8'($urandom);
            mem_read_data   = 8'($urandom);
            mem_read_ready  = is_rd ? (i == rdy_at) : 1'($urandom);
            mem_write_ready = is_rd ? 1'($urandom) : (i == rdy_at);
            if (i == rdy_at) captured = mem_read_data;
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (timed_out) begin
            exp_err = 1'b1;
            if (is_rd) exp_out = 8'h00;
        end else if (is_rd) begin
            exp_out = captured;
        end
        chk("valid_beats", beats, timed_out ? TMO : rdy_at + 1);
        chk("done_state", 32'(lsu_state), 3);
        chk("done_valids_low", {30'd0, mem_read_valid, mem_write_valid}, 0);
        chk("lsu_out", 32'(lsu_out), 32'(exp_out));
        chk("lsu_error", 32'(lsu_error), 32'(exp_err));
        core_state = CORE_EXECUTE;
        repeat (2) begin
            @(negedge clk);
            chk("done_hold", 32'(lsu_state), 3);
            chk("done_out_stable", 32'(lsu_out), 32'(exp_out));
        end
        core_state = CORE_UPDATE;
        @(negedge clk);
        chk("update_to_idle", 32'(lsu_state), 0);
        chk("idle_out_kept", 32'(lsu_out), 32'(exp_out));
        core_state = CORE_IDLE;
    endtask

    initial begin
        reset                    = 1'b1;
        enable                   = 1'b1;
        core_state               = CORE_IDLE;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        rs                       = 8'h00;
        rt                       = 8'h00;
        mem_read_ready           = 1'b0;
        mem_read_data            = 8'h00;
        mem_write_ready          = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // enable low must keep the unit idle even with a load decoded in REQUEST
        enable                  = 1'b0;
        core_state              = CORE_REQUEST;
        decoded_mem_read_enable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("disabled_idle", 32'(lsu_state), 0);
            chk("disabled_no_valid", {30'd0, mem_read_valid, mem_write_valid}, 0);
        end
        enable                  = 1'b1;
        core_state              = CORE_IDLE;
        decoded_mem_read_enable = 1'b0;
        @(negedge clk);

        // read, ready on the fourth WAITING cycle
        run_txn(1'b1, 1'b0, 8'h2A, 8'h00, 3);
        // write, ready on the first WAITING cycle; lsu_out must keep the load result
        run_txn(1'b0, 1'b1, 8'h10, 8'hF0, 0);
        chk("write_kept_out", 32'(lsu_out), 32'(exp_out));
        // both decodes set: only the read side may assert
        run_txn(1'b1, 1'b1, 8'h5A, 8'hA5, 1);
        // ready on the terminal cycle wins over the timeout
        run_txn(1'b1, 1'b0, 8'h44, 8'h00, TMO - 1);
        // read that never sees ready, then a good read with a sticky error
        run_txn(1'b1, 1'b0, 8'h33, 8'h00, TMO);
        run_txn(1'b1, 1'b0, 8'h34, 8'h00, 0);
        run_txn(1'b0, 1'b1, 8'h35, 8'h36, TMO + 1);

        // asynchronous reset in the middle of WAITING
        core_state              = CORE_REQUEST;
        decoded_mem_read_enable = 1'b1;
        rs                      = 8'h77;
        @(negedge clk);
        core_state              = CORE_WAIT;
        decoded_mem_read_enable = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 32'(mem_read_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_out = 8'h00;
        exp_err = 1'b0;
        @(negedge clk);
        reset          = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hAB;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", 32'(lsu_state), 0);
            chk("post_reset_no_valid", {30'd0, mem_read_valid, mem_write_valid}, 0);
            chk("post_reset_out", 32'(lsu_out), 0);
        end
        mem_read_ready = 1'b0;
        core_state     = CORE_IDLE;
        @(negedge clk);

        for (int t = 0; t < 24; t++) begin
            logic rd_r;
            logic wr_r;
            rd_r = 1'($urandom);
            wr_r = rd_r ? 1'($urandom) : 1'b1;
            run_txn(rd_r, wr_r, 8'($urandom), 8'($urandom), int'($urandom_range(0, TMO + 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the memory and result data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles in WAITING before abort.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1 rising-edge clock; reset input 1 asynchronous active-high reset.
REQ-005 Ports SHALL be: enable input 1, thread active; core_state input 3, core pipeline state.
REQ-006 Ports SHALL be: decoded_mem_read_enable input 1, LDR decoded; decoded_mem_write_enable input 1, STR decoded.
REQ-007 Ports SHALL be: rs input 8, address operand; rt input 8, store data operand.
REQ-008 Ports SHALL be: mem_read_valid output 1; mem_read_address output ADDR_BITS; mem_read_ready input 1; mem_read_data input DATA_BITS.
REQ-009 Ports SHALL be: mem_write_valid output 1; mem_write_address output ADDR_BITS; mem_write_data output DATA_BITS; mem_write_ready input 1.
REQ-010 Ports SHALL be: lsu_state output 2, current state; lsu_out output DATA_BITS, load result for the register file MEMORY mux input; lsu_error output 1, sticky timeout flag.

Function
REQ-011 Core states SHALL be decoded as: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-012 lsu_state encoding SHALL be: IDLE 00, REQUESTING 01, WAITING 10, DONE 11.
REQ-013 With enable low, the FSM SHALL remain in IDLE, and both valid outputs SHALL stay low.
REQ-014 IDLE -> REQUESTING SHALL occur on the edge where core_state==REQUEST and either decoded enable is high.
REQ-015 If both decoded enables are high, the operation SHALL be a read and the write SHALL be ignored.
REQ-016 In REQUESTING, the block SHALL register valid high, address=rs[ADDR_BITS-1:0], and for writes data=rt[DATA_BITS-1:0]; the next state SHALL be WAITING.
REQ-017 In WAITING, valid, address and data SHALL hold stable until the matching ready is sampled high.
REQ-018 When read ready is sampled high, lsu_out SHALL capture mem_read_data, valid SHALL drop on the same edge, and the next state SHALL be DONE.
REQ-019 When write ready is sampled high, valid SHALL drop, lsu_out SHALL be unchanged, and the next state SHALL be DONE.
REQ-020 The timeout counter SHALL clear on entry to WAITING and increment each WAITING cycle without ready.
REQ-021 When the timeout count equals TIMEOUT_CYCLES: valid SHALL drop, lsu_error SHALL be set, lsu_out SHALL be set to 0 for reads, and the next state SHALL be DONE.
REQ-022 If ready and timeout occur in the same cycle, ready SHALL win and no error SHALL be raised.
REQ-023 DONE -> IDLE SHALL occur on the edge where core_state==UPDATE; DONE SHALL otherwise hold, so lsu_out stays stable through UPDATE.
REQ-024 Minimum latency SHALL be REQUEST edge -> valid high 1 cycle -> ready seen same cycle -> DONE 2 cycles after the REQUEST edge.
REQ-025 lsu_error SHALL be sticky and SHALL be cleared only by reset.

Reset
REQ-026 Reset assertion SHALL immediately and asynchronously force: state IDLE; both valids 0; addresses, write data, lsu_out and counter 0; lsu_error 0.
REQ-027 Reset mid-transaction SHALL abort it with no retry, and any subsequent ready SHALL be ignored while in IDLE.

Structure
REQ-028 The core_state and lsu_state encodings SHALL be localparams in a shared gpu package used by the core scheduler, register file and this block.
REQ-029 The timeout counter SHALL be a sub-module lsu_timeout_counter with clear, count enable, terminal-count output and TIMEOUT_CYCLES parameter.

Verification
REQ-030 Read, ready after 3 cycles, rs=0x2A, mem_read_data=0x5C -> mem_read_address=0x2A; lsu_out=0x5C in DONE; IDLE after UPDATE.
REQ-031 Write, ready on the first WAITING cycle, rs=0x10, rt=0xF0 -> one valid beat with addr 0x10 and data 0xF0; lsu_out unchanged.
REQ-032 Read with ready never asserted, TIMEOUT_CYCLES=4 -> valid drops after 4 WAITING cycles; lsu_error=1; lsu_out=0; lsu_error persists over the next good read.
REQ-033 Both decoded enables high -> only mem_read_valid asserts; mem_write_valid stays 0 throughout.
REQ-034 Reset asserted mid-WAITING, off-edge -> all outputs 0 before the next clk edge; a later ready is ignored.
REQ-035 enable=0 with core_state=REQUEST and read enable high -> lsu_state stays 00 and no valid is asserted.
